mem_access_unit: RTL and testbench

Data-memory access stage sitting directly downstream of the single-cycle datapath. It takes aluout (address), writedata and the memory controls, and drives a request/acknowledge memory bus. It returns aligned, extended load data to the result mux (readdata), and stalls the PC while an access is outstanding. It adds byte/halfword/word access with byte enables, misalignment detection and a stall-cycle counter.

---
 rtl/mem_access_unit_if.sv | 12 +
 rtl/mem_access_unit.sv | 78 +++++++
 tb/tb_mem_access_unit.sv | 138 +++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: request/acknowledge data-memory bus
interface mem_access_unit_if #(parameter int AW = 32, parameter int DW = 32);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_be;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  modport master(output mem_req, mem_we, mem_addr, mem_wdata, mem_be, input mem_ack, mem_rdata);
  modport slave(input mem_req, mem_we, mem_addr, mem_wdata, mem_be, output mem_ack, mem_rdata);
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store stage driving a req/ack bus with byte lanes, misalign detect and stall counter
module mem_access_unit #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memread,
  input  logic             memwrite,
  input  logic [1:0]       size,
  input  logic             loadsigned,
  input  logic [AW-1:0]    addr,
  input  logic [DW-1:0]    wdata,
  output logic [DW-1:0]    readdata,
  output logic             stall,
  output logic             misalign,
  output logic [CNT_W-1:0] stall_cnt,
  mem_access_unit_if.master bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, next;
  logic access, mis, go, ack, sgn, rd;
  logic [1:0] off, sz;
  logic [3:0] be;
  logic [DW-1:0] wd, ext;
  logic [7:0] b;
  logic [15:0] h;
  always_comb begin
    access   = memread | memwrite;
    mis      = size == 2'b11 || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
    go       = state == IDLE && access && !mis;
    misalign = state == IDLE && access && mis;
    stall    = go || state == BUSY;
    ack      = state == BUSY && bus.mem_ack;
    be       = size == 2'b00 ? 4'b0001 << addr[1:0] : size == 2'b01 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wd       = size == 2'b00 ? {4{wdata[7:0]}} : size == 2'b01 ? {2{wdata[15:0]}} : wdata;
    // extraction uses the offset/size captured at request time, not the live inputs
    b        = bus.mem_rdata[{off, 3'b000} +: 8];
    h        = off[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    ext      = sz == 2'b00 ? {{(DW-8){sgn & b[7]}}, b} : sz == 2'b01 ? {{(DW-16){sgn & h[15]}}, h} : bus.mem_rdata;
    next     = state == IDLE ? (go ? BUSY : IDLE) : state == BUSY ? (bus.mem_ack ? DONE : BUSY) : IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= next;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_be    <= '0;
      readdata      <= '0;
      off           <= '0;
      sz            <= '0;
      sgn           <= 1'b0;
      rd            <= 1'b0;
    end else if (go) begin
      bus.mem_req   <= 1'b1;
      bus.mem_we    <= memwrite;
      bus.mem_addr  <= {addr[AW-1:2], 2'b00};
      bus.mem_wdata <= wd;
      bus.mem_be    <= be;
      off           <= addr[1:0];
      sz            <= size;
      sgn           <= loadsigned;
      rd            <= !memwrite;
    end else if (ack) begin
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      readdata      <= rd ? ext : readdata;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) stall_cnt <= '0;
    else if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: table-driven directed vectors plus hand sequences for reset, stray ack and saturation
module tb_mem_access_unit;
  logic clk = 0, reset = 1, memread = 0, memwrite = 0, loadsigned = 0;
  logic [1:0] size = 0;
  logic [31:0] addr = 0, wdata = 0, readdata;
  logic stall, misalign;
  logic [7:0] stall_cnt;
  int nvec = 0, miscompares = 0;
  mem_access_unit_if #(.AW(32), .DW(32)) bus();
  mem_access_unit #(.AW(32), .DW(32), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite), .size(size),
    .loadsigned(loadsigned), .addr(addr), .wdata(wdata), .readdata(readdata), .stall(stall),
    .misalign(misalign), .stall_cnt(stall_cnt), .bus(bus.master)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic rd, wr; logic [1:0] sz; logic sgn; logic [31:0] a, wd, rdat; int n;
    logic mis, we; logic [3:0] be; logic [31:0] mwd, rdout;
  } vec_t;
  vec_t v[13];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic idle_inputs();
    memread = 0; memwrite = 0; size = 0; loadsigned = 0; addr = 0; wdata = 0; bus.mem_ack = 0;
  endtask
  task automatic run(input vec_t t);
    logic [7:0] c0;
    int st;
    nvec++;
    @(negedge clk);
    memread = t.rd; memwrite = t.wr; size = t.sz; loadsigned = t.sgn;
    addr = t.a; wdata = t.wd; bus.mem_rdata = t.rdat; c0 = stall_cnt;
    #1;
    chk("misalign", misalign, t.mis);
    chk("stall_c0", stall, !t.mis);
    if (t.mis) begin
      @(negedge clk);
      chk("mis_req", bus.mem_req, 0);
      chk("mis_readdata", readdata, t.rdout);
      chk("mis_cnt", stall_cnt, c0);
      idle_inputs();
      return;
    end
    st = 1;
    for (int i = 1; i <= t.n; i++) begin
      @(negedge clk);
      if (i == t.n) bus.mem_ack = 1;
      chk("busy_req", bus.mem_req, 1);
      chk("busy_we", bus.mem_we, t.we);
      chk("busy_addr", bus.mem_addr, t.a & 32'hFFFF_FFFC);
      chk("busy_be", bus.mem_be, t.be);
      chk("busy_wdata", bus.mem_wdata, t.mwd);
      st += stall;
    end
    @(negedge clk);
    bus.mem_ack = 0;
    chk("done_req", bus.mem_req, 0);
    chk("done_we", bus.mem_we, 0);
    chk("done_stall", stall, 0);
    chk("done_readdata", readdata, t.rdout);
    chk("stall_cycles", st, t.n + 1);
    chk("stall_cnt", stall_cnt, c0 + 8'(t.n + 1));
    idle_inputs();
  endtask
  initial begin
    bus.mem_ack = 0; bus.mem_rdata = 0;
    //        rd wr  sz    sgn a          wd            rdat          n  mis we be       mwd           rdout
    v[0]  = '{1, 0, 2'b10, 0, 32'h100, 32'h0,        32'hDEADBEEF, 1, 0, 0, 4'b1111, 32'h0,        32'hDEADBEEF};
    v[1]  = '{1, 0, 2'b00, 1, 32'h103, 32'h0,        32'h80FF0012, 1, 0, 0, 4'b1000, 32'h0,        32'hFFFFFF80};
    v[2]  = '{1, 0, 2'b00, 0, 32'h103, 32'h0,        32'h80FF0012, 1, 0, 0, 4'b1000, 32'h0,        32'h00000080};
    v[3]  = '{0, 1, 2'b01, 0, 32'h022, 32'h1234ABCD, 32'h0,        3, 0, 1, 4'b1100, 32'hABCDABCD, 32'h00000080};
    v[4]  = '{1, 0, 2'b10, 0, 32'h101, 32'h0,        32'h0,        1, 1, 0, 4'b0000, 32'h0,        32'h00000080};
    v[5]  = '{1, 1, 2'b00, 0, 32'h040, 32'h000000A5, 32'h0,        2, 0, 1, 4'b0001, 32'hA5A5A5A5, 32'h00000080};
    v[6]  = '{1, 0, 2'b01, 1, 32'h202, 32'h0,        32'h80017FFF, 1, 0, 0, 4'b1100, 32'h0,        32'hFFFF8001};
    v[7]  = '{1, 0, 2'b01, 0, 32'h200, 32'h0,        32'h8001F00F, 2, 0, 0, 4'b0011, 32'h0,        32'h0000F00F};
    v[8]  = '{1, 0, 2'b00, 1, 32'h301, 32'h0,        32'h00007F00, 1, 0, 0, 4'b0010, 32'h0,        32'h0000007F};
    v[9]  = '{0, 1, 2'b11, 0, 32'h000, 32'h0,        32'h0,        1, 1, 0, 4'b0000, 32'h0,        32'h0000007F};
    v[10] = '{1, 0, 2'b01, 0, 32'h003, 32'h0,        32'h0,        1, 1, 0, 4'b0000, 32'h0,        32'h0000007F};
    v[11] = '{0, 1, 2'b10, 0, 32'h044, 32'h11223344, 32'h0,        1, 0, 1, 4'b1111, 32'h11223344, 32'h0000007F};
    v[12] = '{0, 1, 2'b00, 0, 32'h002, 32'hFFFFFF5A, 32'h0,        1, 0, 1, 4'b0100, 32'h5A5A5A5A, 32'h0000007F};
    repeat (2) @(negedge clk);
    chk("rst_req", bus.mem_req, 0);
    chk("rst_we", bus.mem_we, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_wdata", bus.mem_wdata, 0);
    chk("rst_be", bus.mem_be, 0);
    chk("rst_readdata", readdata, 0);
    chk("rst_cnt", stall_cnt, 0);
    reset = 0;
    foreach (v[i]) run(v[i]);
    // stray ack while idle must not start or finish anything
    nvec++;
    @(negedge clk);
    bus.mem_ack = 1;
    @(negedge clk);
    bus.mem_ack = 0;
    chk("stray_req", bus.mem_req, 0);
    chk("stray_stall", stall, 0);
    chk("stray_readdata", readdata, 32'h0000007F);
    run('{1, 0, 2'b10, 0, 32'h400, 32'h0, 32'h01020304, 2, 0, 0, 4'b1111, 32'h0, 32'h01020304});
    // reset in the middle of a pending load
    nvec++;
    @(negedge clk);
    memread = 1; size = 2'b10; addr = 32'h500; bus.mem_rdata = 32'h12345678;
    @(negedge clk);
    chk("pre_rst_req", bus.mem_req, 1);
    @(negedge clk);
    reset = 1;
    #1;
    chk("midrst_req", bus.mem_req, 0);
    chk("midrst_readdata", readdata, 0);
    chk("midrst_cnt", stall_cnt, 0);
    idle_inputs();
    @(negedge clk);
    reset = 0;
    run('{1, 0, 2'b10, 0, 32'h600, 32'h0, 32'hCAFEF00D, 2, 0, 0, 4'b1111, 32'h0, 32'hCAFEF00D});
    // long wait saturates the 8-bit stall counter
    nvec++;
    @(negedge clk);
    memread = 1; size = 2'b10; addr = 32'h700; bus.mem_rdata = 32'h0BADCAFE;
    repeat (300) @(negedge clk);
    chk("sat_cnt", stall_cnt, 8'hFF);
    chk("sat_req", bus.mem_req, 1);
    bus.mem_ack = 1;
    @(negedge clk);
    bus.mem_ack = 0;
    chk("sat_readdata", readdata, 32'h0BADCAFE);
    idle_inputs();
    @(negedge clk);
    chk("sat_hold", stall_cnt, 8'hFF);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, miscompares);
    $finish;
  end
endmodule
